// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: default widths,
// requester ids and the transaction state encoding.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int TAG_W_DEF  = 4;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD       = 2'd1,
    ST_WDATA     = 2'd2,
    ST_WAIT_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin grant: a lone requester always wins, and on a tie
// the requester that was not granted last wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_grant_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  logic r_last;
  logic w_winner;
  logic w_any;

  // Winner selection and enable-gated one-hot grant.
  always_comb begin
    w_any = |i_req;
    if (i_req == 2'b11) begin
      w_winner = ~r_last;
    end else if (i_req[1]) begin
      w_winner = PORT_D;
    end else begin
      w_winner = PORT_I;
    end
    if (i_grant_en && w_any) begin
      o_grant = (w_winner == PORT_D) ? 2'b10 : 2'b01;
    end else begin
      o_grant = 2'b00;
    end
    o_winner = w_winner;
  end

  // Last-grant memory; starts at D so that I wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= PORT_D;
    end else if (i_grant_en && w_any) begin
      r_last <= w_winner;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the I-cache refill and the
// D-cache refill/writeback paths, one transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_req_rw,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_valid,
  input  logic [TAG_W-1:0]    mem_resp_tag,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e          r_state;
  logic                r_port;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic                r_mem_req_valid;
  logic                r_mem_data_valid;
  logic                r_i_resp_valid;
  logic                r_d_resp_valid;
  logic [DATA_W-1:0]   r_i_resp_data;
  logic [DATA_W-1:0]   r_d_resp_data;

  logic [1:0]          w_grant;
  logic                w_winner;
  logic                w_grant_en;
  logic                w_hs;
  logic [TAG_W-1:0]    w_tag;
  logic                w_tag_hit;

  // Readies are only ever offered in IDLE and are forced low while in reset.
  assign w_grant_en = (r_state == ST_IDLE) && reset_n;
  assign w_hs       = |w_grant;
  assign w_tag      = {{(TAG_W-1){1'b0}}, r_port};
  assign w_tag_hit  = mem_resp_valid && (mem_resp_tag == w_tag);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_grant_en (w_grant_en),
    .i_req      ({d_req_valid, i_req_valid}),
    .o_grant    (w_grant),
    .o_winner   (w_winner)
  );

  assign i_req_ready        = w_grant[0];
  assign d_req_ready        = w_grant[1];
  assign mem_req_valid      = r_mem_req_valid;
  assign mem_req_rw         = r_rw;
  assign mem_req_addr       = r_addr;
  assign mem_req_tag        = w_tag;
  assign mem_req_data_valid = r_mem_data_valid;
  assign mem_req_data_bits  = r_wdata;
  assign mem_req_data_mask  = r_wmask;
  assign i_resp_valid       = r_i_resp_valid;
  assign i_resp_data        = r_i_resp_data;
  assign d_resp_valid       = r_d_resp_valid;
  assign d_resp_data        = r_d_resp_data;

  // Transaction FSM with all downstream and response outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_port           <= PORT_I;
      r_rw             <= 1'b0;
      r_addr           <= {ADDR_W{1'b0}};
      r_wdata          <= {DATA_W{1'b0}};
      r_wmask          <= {MASK_W{1'b0}};
      r_mem_req_valid  <= 1'b0;
      r_mem_data_valid <= 1'b0;
      r_i_resp_valid   <= 1'b0;
      r_d_resp_valid   <= 1'b0;
      r_i_resp_data    <= {DATA_W{1'b0}};
      r_d_resp_data    <= {DATA_W{1'b0}};
    end else begin
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_port          <= w_winner;
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_CMD;
            if (w_winner == PORT_D) begin
              r_rw    <= d_req_rw;
              r_addr  <= d_req_addr;
              r_wdata <= d_req_wdata;
              r_wmask <= d_req_wmask;
            end else begin
              r_rw    <= 1'b0;
              r_addr  <= i_req_addr;
              r_wdata <= {DATA_W{1'b0}};
              r_wmask <= {MASK_W{1'b0}};
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CMD: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            if (r_rw) begin
              r_mem_data_valid <= 1'b1;
              r_state          <= ST_WDATA;
            end else begin
              r_state <= ST_WAIT_RESP;
            end
          end else begin
            r_state <= ST_CMD;
          end
        end
        ST_WDATA: begin
          if (mem_req_data_ready) begin
            r_mem_data_valid <= 1'b0;
            r_state          <= ST_IDLE;
          end else begin
            r_state <= ST_WDATA;
          end
        end
        ST_WAIT_RESP: begin
          // Responses carrying another tag are not ours; keep waiting.
          if (w_tag_hit) begin
            if (r_port == PORT_D) begin
              r_d_resp_valid <= 1'b1;
              r_d_resp_data  <= mem_resp_data;
            end else begin
              r_i_resp_valid <= 1'b1;
              r_i_resp_data  <= mem_resp_data;
            end
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT_RESP;
          end
        end
        default: begin
          r_mem_req_valid  <= 1'b0;
          r_mem_data_valid <= 1'b0;
          r_state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
